// File: rtl/data_write_port.sv
// data_write_port
// Memory-side responder for the pipeline's data-write request interface.
// A request is captured into a small posted-write buffer and acknowledged with
// a one-cycle data_valid pulse. Buffered writes drain in order onto a
// word-wide bus that may insert wait states.
//
// The buffer has no control FSM: occupancy, the two pointers and the
// acknowledge flag are its whole state.
//
// Every output comes from a register or from count/storage/read pointer.
// No input has a combinational path to any output.

module data_write_port #(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          address_enable,
    input  logic [31:0]   address,
    input  logic [31:0]   data,
    output logic          data_valid,
    output logic          mem_write,
    output logic [31:0]   mem_address,
    output logic [31:0]   mem_writedata,
    input  logic          mem_waitrequest,
    output logic          pending,
    output logic [CW-1:0] count
);

    // Storage holds only the word address. The byte offset is not
    // meaningful on a word-only bus.
    logic [29:0] buf_addr [DEPTH];
    logic [31:0] buf_data [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic full;
    logic accept;
    logic pop;

    // The byte-lane bits of the request address are intentionally dropped.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^address[1:0];

    // Accept and pop decisions use only registered state and the current inputs.
    // A full buffer blocks accept even when a pop happens on the same edge.
    // This keeps mem_waitrequest out of the accept decision.
    always_comb begin
        full      = (count == CW'(DEPTH));
        accept    = address_enable && !data_valid && !full;
        mem_write = (count != '0);
        pop       = mem_write && !mem_waitrequest;
    end

    assign pending       = mem_write;
    assign mem_address   = {buf_addr[rd_ptr], 2'b00};
    assign mem_writedata = buf_data[rd_ptr];

    // data_valid acknowledges the request captured on the previous edge.
    // While it is high, the next request is ignored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_valid <= 1'b0;
        end else begin
            data_valid <= accept;
        end
    end

    // Occupancy tracks push and pop. Doing both on one edge leaves it unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Buffer storage is cleared on reset so that the bus outputs idle at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_addr[i] <= '0;
                buf_data[i] <= '0;
            end
        end else if (accept) begin
            buf_addr[wr_ptr] <= address[31:2];
            buf_data[wr_ptr] <= data;
        end
    end

    generate
        if (DEPTH > 1) begin : g_ptrs
            // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + PW'(1);
                    end
                    if (pop) begin
                        rd_ptr <= rd_ptr + PW'(1);
                    end
                end
            end
        end else begin : g_no_ptrs
            // A single entry needs no pointers. Storage is always at index zero.
            assign wr_ptr = '0;
            assign rd_ptr = '0;
        end
    endgenerate

endmodule

// File: tb/tb_data_write_port.sv
// Directed testbench for data_write_port (DEPTH = 2).
// Inputs are driven 1 ns after the rising edge. Outputs are checked at that
// same point, which is within the cycle that follows the edge.

module tb_data_write_port;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        address_enable = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] data = '0;
    logic        mem_waitrequest = 1'b0;
    logic        data_valid;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic        pending;
    logic [1:0]  count;

    int n_checks = 0;
    int n_fail   = 0;
    bit toggle_wr = 1'b0;

    logic [31:0] obs_addr [$];
    logic [31:0] obs_data [$];
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];

    data_write_port #(.DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .address_enable  (address_enable),
        .address         (address),
        .data            (data),
        .data_valid      (data_valid),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_writedata   (mem_writedata),
        .mem_waitrequest (mem_waitrequest),
        .pending         (pending),
        .count           (count)
    );

    always #5 clock = ~clock;

    // Bus monitor: a beat on which the head will be consumed at the next edge.
    always @(negedge clock) begin
        if (!reset && mem_write && !mem_waitrequest) begin
            obs_addr.push_back(mem_address);
            obs_data.push_back(mem_writedata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (toggle_wr) mem_waitrequest = ~mem_waitrequest;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_dv"},    32'(data_valid),  32'd0);
        check({tag, "_mw"},    32'(mem_write),   32'd0);
        check({tag, "_maddr"}, mem_address,      32'd0);
        check({tag, "_mdata"}, mem_writedata,    32'd0);
        check({tag, "_pend"},  32'(pending),     32'd0);
        check({tag, "_count"}, 32'(count),       32'd0);
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        exp_addr.push_back({a[31:2], 2'b00});
        exp_data.push_back(d);
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (count != 2'd0 && n < max_cycles) begin
            tick();
            n++;
        end
        check({tag, "_drain"}, 32'(count), 32'd0);
    endtask

    task automatic compare_bus(input string tag);
        int n;
        check({tag, "_nbeats"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
        n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), obs_addr[i], exp_addr[i]);
            check($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
        end
        obs_addr.delete(); obs_data.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset
        #2 reset = 1'b1;
        #1 check_idle("reset");
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check_idle("post_reset");

        // Single write with the byte offset discarded
        mem_waitrequest = 1'b0;
        address = 32'h0000_1007; data = 32'hDEAD_BEEF; address_enable = 1'b1;
        expect_write(32'h0000_1007, 32'hDEAD_BEEF);
        tick();
        check("single_dv",    32'(data_valid), 32'd1);
        check("single_mw",    32'(mem_write),  32'd1);
        check("single_maddr", mem_address,     32'h0000_1004);
        check("single_mdata", mem_writedata,   32'hDEAD_BEEF);
        check("single_count", 32'(count),      32'd1);
        tick();
        address_enable = 1'b0;
        check("single_dv_off", 32'(data_valid), 32'd0);
        check("single_pend",   32'(pending),    32'd0);
        check("single_count0", 32'(count),      32'd0);
        compare_bus("single");

        // Held request: one accept every two cycles
        for (int k = 0; k < 6; k++) begin
            address = 32'h0000_2000; data = 32'(k / 2 + 1); address_enable = 1'b1;
            check($sformatf("held_dv%0d", k), 32'(data_valid), 32'(k % 2));
            tick();
        end
        address_enable = 1'b0;
        check("held_dv6", 32'(data_valid), 32'd0);
        expect_write(32'h2000, 32'd1);
        expect_write(32'h2000, 32'd2);
        expect_write(32'h2000, 32'd3);
        drain("held", 20);
        compare_bus("held");

        // Full stall: C must wait until a pop frees a slot
        mem_waitrequest = 1'b1;
        address = 32'h3000; data = 32'hAAAA; address_enable = 1'b1;
        tick();
        check("full_a_dv", 32'(data_valid), 32'd1);
        check("full_a_cnt", 32'(count), 32'd1);
        tick();
        address = 32'h3004; data = 32'hBBBB;
        check("full_gap_dv", 32'(data_valid), 32'd0);
        tick();
        check("full_b_dv", 32'(data_valid), 32'd1);
        check("full_b_cnt", 32'(count), 32'd2);
        tick();
        address = 32'h3008; data = 32'hCCCC;
        check("full_c_blk1", 32'(data_valid), 32'd0);
        tick();
        check("full_c_blk2", 32'(data_valid), 32'd0);
        check("full_cnt2",   32'(count), 32'd2);
        check("full_head_a", mem_address, 32'h3000);
        mem_waitrequest = 1'b0;
        tick();
        mem_waitrequest = 1'b1;
        check("full_pop_dv",  32'(data_valid), 32'd0);
        check("full_pop_cnt", 32'(count), 32'd1);
        check("full_head_b",  mem_address, 32'h3004);
        tick();
        address_enable = 1'b0;
        check("full_c_dv",  32'(data_valid), 32'd1);
        check("full_c_cnt", 32'(count), 32'd2);
        mem_waitrequest = 1'b0;
        expect_write(32'h3000, 32'hAAAA);
        expect_write(32'h3004, 32'hBBBB);
        expect_write(32'h3008, 32'hCCCC);
        drain("full", 20);
        compare_bus("full");

        // Simultaneous push and pop
        mem_waitrequest = 1'b1;
        address = 32'h4000; data = 32'h1111; address_enable = 1'b1;
        tick();
        address_enable = 1'b0;
        check("pp_x_cnt", 32'(count), 32'd1);
        tick();
        mem_waitrequest = 1'b0;
        address = 32'h4010; data = 32'h2222; address_enable = 1'b1;
        tick();
        address_enable = 1'b0;
        check("pp_dv",    32'(data_valid), 32'd1);
        check("pp_cnt",   32'(count), 32'd1);
        check("pp_maddr", mem_address, 32'h4010);
        check("pp_mdata", mem_writedata, 32'h2222);
        expect_write(32'h4000, 32'h1111);
        expect_write(32'h4010, 32'h2222);
        drain("pp", 20);
        compare_bus("pp");

        // Wrap-around with a toggling stall
        mem_waitrequest = 1'b0;
        toggle_wr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            address = 32'h5000 + 32'(i * 4 + i % 4);
            data = 32'hC0DE_0000 + 32'(i);
            address_enable = 1'b1;
            expect_write(address, data);
            n = 0;
            do begin
                tick();
                n++;
            end while (!data_valid && n < 20);
            check($sformatf("wrap_ack%0d", i), 32'(data_valid), 32'd1);
        end
        tick();
        address_enable = 1'b0;
        drain("wrap", 40);
        toggle_wr = 1'b0;
        mem_waitrequest = 1'b0;
        compare_bus("wrap");

        // Reset mid-cycle with a full buffer and an acknowledge in flight
        mem_waitrequest = 1'b1;
        address = 32'h6000; data = 32'h6666; address_enable = 1'b1;
        tick();
        tick();
        address = 32'h6004; data = 32'h7777;
        tick();
        check("mr_pre_dv",  32'(data_valid), 32'd1);
        check("mr_pre_cnt", 32'(count), 32'd2);
        #2 reset = 1'b1;
        #1 check_idle("midreset");
        @(posedge clock);
        #1 reset = 1'b0;
        address_enable = 1'b0;
        mem_waitrequest = 1'b0;
        obs_addr.delete(); obs_data.delete();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("mr_stale_mw%0d", k), 32'(mem_write), 32'd0);
            tick();
        end
        check("mr_stale_beats", 32'(obs_addr.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
